// File: rtl/adder_pipe.sv
// Pipelined W-bit adder/subtractor split into S chunk stages of W/S bits.
// The carry is registered between stages. Operand chunks are skewed in so
// that each chunk meets its carry, and result chunks are deskewed out so
// that y, cout and ovf appear together. A valid/ready stream interface
// stalls the whole pipe with one global advance enable.

// Enable-gated delay line of D (>= 1) words, each WD bits wide.
module adder_pipe_dly #(
    parameter int WD = 1,
    parameter int D  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [WD-1:0] d,
    output logic [WD-1:0] q
);

    // The newest word enters at the low end; the oldest word leaves at the top.
    logic [D*WD-1:0] r_sr;

    if (D == 1) begin : g_one
        // Single register stage.
        always_ff @(posedge clk or posedge rst) begin
            // NOTE: data registers are reset as well so that y/cout/ovf leave reset as 0, not X.
            if (rst)     r_sr <= '0;
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            else if (en) r_sr <= d;
        end
    end else begin : g_many
        // Shift the whole line by one word when the pipe advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     r_sr <= '0;
            else if (en) r_sr <= {r_sr[(D-1)*WD-1:0], d};
        end
    end

    assign q = r_sr[D*WD-1 -: WD];

endmodule

module adder_pipe #(
    parameter int W = 8,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         cout,
    output logic         ovf
);

    localparam int C = W / S;

    if (S < 1) begin : g_bad_stages
        $error("adder_pipe: S must be at least 1");
    end else if (W % S != 0) begin : g_bad_split
        $error("adder_pipe: W must be divisible by S");
    end

    logic         w_en;
    logic [S-1:0] r_vld;
    logic [W-1:0] w_b_eff;
    logic         w_c0;
    logic [S-1:0] w_carry;   // registered carry out of each stage; top bit is cout
    logic [W-1:0] w_y;

    // Every stage advances together unless a finished result is being held.
    assign w_en      = out_ready || !r_vld[S-1];
    assign in_ready  = w_en;
    assign out_valid = r_vld[S-1];
    assign w_b_eff   = sub ? ~b : b;
    assign w_c0      = sub ? 1'b1 : cin;
    assign cout      = w_carry[S-1];
    assign y         = w_y;

    // Valid bits travel alongside the data; a bubble enters whenever in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < S; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [C-1:0] w_ak;
        logic [C-1:0] w_bk;
        logic         w_ci;
        logic [C:0]   w_add;
        logic         r_co;

        if (k == 0) begin : g_head
            assign w_ak = a[C-1:0];
            assign w_bk = w_b_eff[C-1:0];
            assign w_ci = w_c0;
        end else begin : g_skew
            logic [2*C-1:0] w_skew_q;

            // Chunk k of both operands waits k cycles for the carry from below.
            adder_pipe_dly #(.WD(2*C), .D(k)) u_skew (
                .clk (clk),
                .rst (rst),
                .en  (w_en),
                .d   ({a[k*C +: C], w_b_eff[k*C +: C]}),
                .q   (w_skew_q)
            );

            assign {w_ak, w_bk} = w_skew_q;
            assign w_ci         = w_carry[k-1];
        end

        assign w_add = {1'b0, w_ak} + {1'b0, w_bk} + {{C{1'b0}}, w_ci};

        // Carry out of this chunk, handed to the next stage on the next cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)       r_co <= 1'b0;
            else if (w_en) r_co <= w_add[C];
        end

        assign w_carry[k] = r_co;

        // First element is the stage register; the remaining S-1-k align the chunk with the top.
        adder_pipe_dly #(.WD(C), .D(S-k)) u_deskew (
            .clk (clk),
            .rst (rst),
            .en  (w_en),
            .d   (w_add[C-1:0]),
            .q   (w_y[k*C +: C])
        );

        if (k == S-1) begin : g_tail
            logic r_ovf;

            // Overflow is carry into the MSB (a ^ b ^ sum at that bit) XOR carry out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)       r_ovf <= 1'b0;
                else if (w_en) r_ovf <= w_ak[C-1] ^ w_bk[C-1] ^ w_add[C-1] ^ w_add[C];
            end

            assign ovf = r_ovf;
        end
    end

endmodule
